// File: rtl/alu_pkg.sv
// Shared opcode constants and the command record used by alu_cmd_issue and its queue.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    alu_op_e    op;
  } alu_cmd_t;

  // Saturating 8-bit increment for the optional statistics counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for alu_cmd_issue: DEPTH-entry circular buffer with push/pop, full/empty and clear.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  alu_cmd_t wdata,
  output alu_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  alu_cmd_t      mem_q [DEPTH];

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Queues ALU commands, issues the head to an external combinational ALU and registers its result.
// Optional statistics counters are enabled with `define ALU_CMD_STATS_EN.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_a,
  input  logic [1:0] in_b,
  input  logic [2:0] in_op,
  input  logic       flush,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [1:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_out,
  output logic       res_z,
  output logic       res_c,
  output logic [2:0] res_op
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [7:0] stat_issued,
  output logic [7:0] stat_carry
`endif
);

  alu_cmd_t   head;
  alu_cmd_t   in_cmd;
  logic       full, empty;
  logic       push, issue;

  logic       res_valid_q, res_valid_d;
  logic [1:0] res_out_q, res_out_d;
  logic       res_z_q, res_z_d;
  logic       res_c_q, res_c_d;
  logic [2:0] res_op_q, res_op_d;

  assign in_cmd   = '{a: in_a, b: in_b, op: alu_op_e'(in_op)};
  assign in_ready = !full;
  // Flush overrides both sides of the queue in the same cycle.
  assign push     = in_valid && in_ready && !flush;
  assign issue    = !empty && (!res_valid_q || res_ready) && !flush;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (issue),
    .wdata (in_cmd),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign alu_a  = head.a;
  assign alu_b  = head.b;
  assign alu_op = head.op;

  always_comb begin
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_z_d     = res_z_q;
    res_c_d     = res_c_q;
    res_op_d    = res_op_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (issue) begin
      res_valid_d = 1'b1;
      res_out_d   = alu_out;
      res_z_d     = alu_z;
      res_c_d     = alu_c;
      res_op_d    = head.op;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_z_q     <= 1'b0;
      res_c_q     <= 1'b0;
      res_op_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_z_q     <= res_z_d;
      res_c_q     <= res_c_d;
      res_op_q    <= res_op_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_z     = res_z_q;
  assign res_c     = res_c_q;
  assign res_op    = res_op_q;

`ifdef ALU_CMD_STATS_EN
  logic [7:0] stat_issued_q, stat_issued_d;
  logic [7:0] stat_carry_q, stat_carry_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_carry_d  = stat_carry_q;
    if (issue) begin
      stat_issued_d = sat_inc8(stat_issued_q);
      if (alu_c) stat_carry_d = sat_inc8(stat_carry_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_carry_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_carry_q  <= stat_carry_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_carry  = stat_carry_q;
`endif

endmodule
